// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and helpers for the FIFO enqueue arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_WIDTH = 32;

    // Wrapping increment of the round-robin pointer; n need not be a power of two.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotate-priority picker: first set request scanning upward from rr_ptr, with wrap.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any_req,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    int unsigned idx;

    // Scan from the far end down so the candidate closest to rr_ptr is written last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 32'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = 32'(rr_ptr) + 32'(k);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDW'(idx)]) begin
                any_req = 1'b1;
                winner  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO enqueue port among NUM_REQ producers.
// Optional per-requester/grant statistics are enabled by defining FIFO_ARB_STATS_EN.
module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DWIDTH    = 64,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DWIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_in_enque_en,
    output logic [DWIDTH-1:0]             fifo_in_data,
    input  logic                          fifo_in_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] xfer_count,
    output logic [STAT_WIDTH-1:0]         grant_count
`endif
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           any_req;
    logic [IDW-1:0] winner;
    logic           owner_valid;
    logic           xfer;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_q),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    // Next state plus the combinational enqueue path; outputs follow state so reset clears them at once.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_d             = rr_q;
        beat_d           = beat_q;
        req_ready        = '0;
        fifo_in_enque_en = 1'b0;
        fifo_in_data     = '0;
        grant_id         = '0;
        busy             = 1'b0;
        owner_valid      = req_valid[owner_q];
        xfer             = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BURST;
                    owner_d = winner;
                    beat_d  = '0;
                end
            end
            BURST: begin
                busy               = 1'b1;
                grant_id           = owner_q;
                req_ready[owner_q] = fifo_in_valid;
                xfer               = owner_valid && fifo_in_valid;
                fifo_in_enque_en   = xfer;
                fifo_in_data       = req_data[32'(owner_q)*DWIDTH +: DWIDTH];
                // A dropped valid releases even when the FIFO is full; a full FIFO alone never does.
                if (!owner_valid || (xfer && beat_q == BW'(MAX_BURST - 1))) begin
                    state_d = IDLE;
                    rr_d    = IDW'(rr_next(32'(owner_q), NUM_REQ));
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count  <= '0;
            grant_count <= '0;
        end else begin
            if (xfer) begin
                xfer_count[32'(owner_q)*STAT_WIDTH +: STAT_WIDTH] <=
                    xfer_count[32'(owner_q)*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
            end
            if (state_q == IDLE && any_req) begin
                grant_count <= grant_count + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Randomized and directed bench for fifo_enq_arbiter against a cycle-level behavioural model.
module tb_fifo_enq_arbiter;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int MB    = 4;
    localparam int DEPTH = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_in_enque_en;
    logic [DW-1:0]     fifo_in_data;
    logic              fifo_in_valid;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*32-1:0]   xfer_count;
    logic [31:0]       grant_count;
    int                m_xfer[N];
    int                m_grants;
`endif

    always #5 clk = ~clk;

    fifo_enq_arbiter #(
        .NUM_REQ   (N),
        .DWIDTH    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_in_enque_en (fifo_in_enque_en),
        .fifo_in_data     (fifo_in_data),
        .fifo_in_valid    (fifo_in_valid),
        .grant_id         (grant_id),
        .busy             (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .xfer_count       (xfer_count),
        .grant_count      (grant_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Producer queues
    logic [DW-1:0] pdata [N][DEPTH];
    int            head [N];
    int            tail [N];

    // Reference model: who owns the port, beats taken, next scan start
    bit m_busy;
    int m_owner, m_cnt, m_ptr;

    // Log of what the DUT actually enqueued
    logic [DW-1:0] log_data [DEPTH];
    int            log_cyc  [DEPTH];
    int            log_n;
    int            cyc;

    function automatic void push(input int id, input logic [DW-1:0] d);
        if (tail[id] < DEPTH) begin
            pdata[id][tail[id]] = d;
            tail[id]++;
        end
    endfunction

    task automatic run_cycle(input logic [N-1:0] en, input logic fv);
        logic [N-1:0]  e_ready;
        logic          e_enq;
        logic [DW-1:0] e_data;
        logic [1:0]    e_gid;
        logic          e_busy;
        bit            found;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (head[i] < tail[i]);
            req_data[i*DW +: DW] = req_valid[i] ? pdata[i][head[i]] : (64'hdead_beef_0000_0000 | 64'(i));
        end
        fifo_in_valid = fv;
        @(negedge clk);
        e_ready = '0; e_enq = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0;
        if (!rst && m_busy) begin
            e_busy           = 1'b1;
            e_gid            = 2'(m_owner);
            e_ready[m_owner] = fv;
            e_enq            = req_valid[m_owner] && fv;
            e_data           = req_data[m_owner*DW +: DW];
        end
        n_cmp++;
        if ({req_ready, fifo_in_enque_en, grant_id, busy} !== {e_ready, e_enq, e_gid, e_busy}) begin
            $display("FAIL ctrl cyc=%0d got ready=%b enq=%b gid=%0d busy=%b exp ready=%b enq=%b gid=%0d busy=%b",
                     cyc, req_ready, fifo_in_enque_en, grant_id, busy, e_ready, e_enq, e_gid, e_busy);
            n_err++;
        end
        n_cmp++;
        if (fifo_in_data !== e_data) begin
            $display("FAIL data cyc=%0d got=%h exp=%h", cyc, fifo_in_data, e_data);
            n_err++;
        end
        if (fifo_in_enque_en === 1'b1 && log_n < DEPTH) begin
            log_data[log_n] = fifo_in_data;
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
`ifdef FIFO_ARB_STATS_EN
            m_grants = 0;
            for (int i = 0; i < N; i++) m_xfer[i] = 0;
`endif
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
`ifdef FIFO_ARB_STATS_EN
                    m_grants++;
`endif
                end
            end
        end else begin
            if (e_enq) begin
                head[m_owner]++;
                m_cnt++;
`ifdef FIFO_ARB_STATS_EN
                m_xfer[m_owner]++;
`endif
            end
            if (!req_valid[m_owner] || m_cnt == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        run_cycle('0, 1'b1);
        run_cycle('0, 1'b1);
        rst   = 1'b0;
        log_n = 0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) push(i, 64'(i + 1));
        run_cycle(4'hf, 1'b1);
        run_cycle(4'hf, 1'b1);
        n_cmp++;
        if (log_n != 0) begin
            $display("FAIL reset_enq got=%0d enqueues exp=0", log_n);
            n_err++;
        end
    endtask

    task automatic test_single();
        int off[6] = '{0, 1, 2, 3, 5, 6};
        apply_reset();
        for (int b = 1; b <= 6; b++) push(0, 64'(b));
        for (int c = 0; c < 40 && log_n < 6; c++) run_cycle(4'b0001, 1'b1);
        n_cmp++;
        if (log_n != 6) begin
            $display("FAIL single_count got=%0d exp=6", log_n);
            n_err++;
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (log_data[k] !== 64'(k + 1) || log_cyc[k] - log_cyc[0] != off[k]) begin
                    $display("FAIL single_beat k=%0d got data=%0d off=%0d exp data=%0d off=%0d",
                             k, log_data[k], log_cyc[k] - log_cyc[0], k + 1, off[k]);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_all_four();
        int exp_d, gap;
        apply_reset();
        for (int i = 0; i < N; i++)
            for (int b = 1; b <= 20; b++) push(i, 64'(i * 100 + b));
        for (int c = 0; c < 100 && log_n < 20; c++) run_cycle(4'hf, 1'b1);
        n_cmp++;
        if (log_n < 20) begin
            $display("FAIL all4_count got=%0d exp=20", log_n);
            n_err++;
        end else begin
            for (int k = 0; k < 20; k++) begin
                exp_d = ((k / 4) % 4) * 100 + (k / 16) * 4 + (k % 4) + 1;
                gap   = (k == 0) ? 0 : ((k % 4 == 0) ? 2 : 1);
                n_cmp++;
                if (log_data[k] !== 64'(exp_d) || (k > 0 && log_cyc[k] - log_cyc[k-1] != gap)) begin
                    $display("FAIL all4_beat k=%0d got data=%0d exp data=%0d gap exp=%0d",
                             k, log_data[k], exp_d, gap);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int   stall = 3;
        logic fv;
        apply_reset();
        for (int b = 1; b <= 4; b++) push(2, 64'(200 + b));
        for (int c = 0; c < 40 && log_n < 4; c++) begin
            fv = !(log_n == 2 && stall > 0);
            if (!fv) stall--;
            run_cycle(4'b0100, fv);
        end
        n_cmp++;
        if (log_n != 4 || log_data[2] !== 64'd203 || log_cyc[2] - log_cyc[1] != 4) begin
            $display("FAIL stall_resume got n=%0d beat3=%0d gap=%0d exp n=4 beat3=203 gap=4",
                     log_n, log_data[2], log_cyc[2] - log_cyc[1]);
            n_err++;
        end
    endtask

    task automatic test_valid_drop();
        apply_reset();
        push(1, 64'd101);
        for (int b = 1; b <= 4; b++) push(3, 64'(300 + b));
        for (int c = 0; c < 40 && log_n < 2; c++) run_cycle(4'b1010, 1'b1);
        n_cmp++;
        if (log_data[0] !== 64'd101 || log_data[1] !== 64'd301 || log_cyc[1] - log_cyc[0] != 3) begin
            $display("FAIL drop_handoff got %0d,%0d gap=%0d exp 101,301 gap=3",
                     log_data[0], log_data[1], log_cyc[1] - log_cyc[0]);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int b = 1; b <= 4; b++) push(3, 64'(300 + b));
        for (int c = 0; c < 40 && log_n < 2; c++) run_cycle(4'b1000, 1'b1);
        rst = 1'b1;
        run_cycle(4'b1000, 1'b1);
        n_cmp++;
        if (log_n != 2) begin
            $display("FAIL midrst_enq got=%0d enqueues exp=2", log_n);
            n_err++;
        end
        push(1, 64'd101);
        push(1, 64'd102);
        run_cycle(4'b1010, 1'b1);
        rst   = 1'b0;
        log_n = 0;
        for (int c = 0; c < 20 && log_n < 1; c++) run_cycle(4'b1010, 1'b1);
        n_cmp++;
        if (log_n < 1 || log_data[0] !== 64'd101) begin
            $display("FAIL midrst_first got n=%0d data=%0d exp data=101", log_n, log_data[0]);
            n_err++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 1) == 0) push(int'($urandom_range(0, N - 1)), {$urandom, $urandom});
            rst = ($urandom_range(0, 99) == 0);
            run_cycle(4'($urandom) | 4'($urandom), $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < N; i++)
            for (int b = 1; b <= 15; b++) push(i, 64'(i * 100 + b));
        for (int c = 0; c < 300 && log_n < 40; c++) run_cycle(4'hf, 1'b1);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (xfer_count[i*32 +: 32] !== 32'(m_xfer[i])) begin
                $display("FAIL xfer_count[%0d] got=%0d exp=%0d", i, xfer_count[i*32 +: 32], m_xfer[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (grant_count !== 32'(m_grants) || m_grants != 10) begin
            $display("FAIL grant_count got=%0d exp=%0d", grant_count, m_grants);
            n_err++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (xfer_count !== '0 || grant_count !== '0) begin
            $display("FAIL stats_clear got xfer=%h grant=%0d exp 0", xfer_count, grant_count);
            n_err++;
        end
        @(posedge clk);
        #1;
        apply_reset();
    endtask
`endif

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        fifo_in_valid = 1'b0;
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        log_n = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
`ifdef FIFO_ARB_STATS_EN
        m_grants = 0;
        for (int i = 0; i < N; i++) m_xfer[i] = 0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_four();
        test_full_stall();
        test_valid_drop();
        test_reset_mid();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
